ipv4_checksum_arbiter: RTL and testbench

Shares one combinational `ipv4_checksum_calculator` among `NUM_REQ` header-producing requesters.
- Each requester presents a packed IPv4 header (fields only, checksum excluded) with a valid/ready handshake.
- The arbiter grants one requester at a time, registers the header, and registers the calculator result.
- It returns the checksum with the requester ID on a single response channel.
- It sits between the per-flow packet builders and the shared checksum datapath in the accelerator.

---
 rtl/ipv4_checksum_arbiter.sv | 148 ++++++++++++++
 tb/tb_ipv4_checksum_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_checksum_arbiter.sv
// Shares one combinational IPv4 header checksum calculator among NUM_REQ requesters.
// Define IPV4_CKSUM_FIXED_PRIO_EN for fixed-priority arbitration (default: round-robin).

module ipv4_checksum_calculator (
    input  logic [143:0] HDR,
    output logic [15:0]  CHECKSUM
);
    // Nine 16-bit words sum to at most 20 bits; two end-around passes always suffice.
    function automatic logic [15:0] ones_fold(input logic [19:0] acc);
        logic [16:0] s1;
        s1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        return s1[15:0] + {15'd0, s1[16]};
    endfunction

    logic [19:0] word_sum;

    always_comb begin
        word_sum = '0;
        for (int i = 0; i < 9; i++) begin
            word_sum = word_sum + {4'd0, HDR[16*i +: 16]};
        end
        CHECKSUM = ~ones_fold(word_sum);
    end
endmodule

module ipv4_checksum_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    output logic [NUM_REQ-1:0]     REQ_READY,
    input  logic [NUM_REQ*144-1:0] REQ_HDR,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [ID_W-1:0]        RSP_ID,
    output logic [15:0]            RSP_CHECKSUM,
    output logic                   BUSY
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state_q, state_d;
    logic [143:0]    hdr_q;
    logic [143:0]    win_hdr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            any_valid;
    logic            accept;
    logic [15:0]     calc_checksum;

`ifndef IPV4_CKSUM_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr_q;

    // Pointer advances past the served requester only once its response is taken.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ptr_q <= '0;
        end else if (state_q == RESP && RSP_READY) begin
            ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
    end
`endif

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
`ifdef IPV4_CKSUM_FIXED_PRIO_EN
        // Descending scan so the lowest valid index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'(i);
            if (REQ_VALID[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i >= NUM_REQ) ? ID_W'(int'(ptr_q) + i - NUM_REQ)
                                                 : ID_W'(int'(ptr_q) + i);
            if (!any_valid && REQ_VALID[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        win_hdr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) win_hdr = REQ_HDR[144*i +: 144];
        end
    end

    always_comb begin
        state_d   = state_q;
        REQ_READY = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    REQ_READY[winner] = 1'b1;
                    accept            = 1'b1;
                    state_d           = CALC;
                end
            end
            CALC:    state_d = RESP;
            RESP:    if (RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BUSY = (state_q != IDLE);

    ipv4_checksum_calculator u_calc (
        .HDR      (hdr_q),
        .CHECKSUM (calc_checksum)
    );

    // Stage boundary: granted header captured, result registered one cycle later.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            id_q         <= '0;
            RSP_VALID    <= 1'b0;
            RSP_ID       <= '0;
            RSP_CHECKSUM <= '0;
        end else begin
            state_q <= state_d;
            if (accept) id_q <= winner;
            if (state_q == CALC) begin
                RSP_VALID    <= 1'b1;
                RSP_ID       <= id_q;
                RSP_CHECKSUM <= calc_checksum;
            end else if (state_q == RESP && RSP_READY) begin
                RSP_VALID <= 1'b0;
            end
        end
    end

    // Header is pure data; it is only consumed after a capture, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (accept) hdr_q <= win_hdr;
    end
endmodule

// File: tb/tb_ipv4_checksum_arbiter.sv
// Directed bench for ipv4_checksum_arbiter: expected responses are queued as requests
// are issued and matched in order against the response channel.
module tb_ipv4_checksum_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   CLK = 1'b0;
    logic                   RESETN;
    logic [NUM_REQ-1:0]     REQ_VALID;
    logic [NUM_REQ-1:0]     REQ_READY;
    logic [NUM_REQ*144-1:0] REQ_HDR;
    logic                   RSP_VALID;
    logic                   RSP_READY;
    logic [ID_W-1:0]        RSP_ID;
    logic [15:0]            RSP_CHECKSUM;
    logic                   BUSY;

    int          total   = 0;
    int          bad     = 0;
    int          rsp_cnt = 0;
    int          cyc     = 0;
    logic [17:0] sb[$];

    ipv4_checksum_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_HDR      (REQ_HDR),
        .RSP_VALID    (RSP_VALID),
        .RSP_READY    (RSP_READY),
        .RSP_ID       (RSP_ID),
        .RSP_CHECKSUM (RSP_CHECKSUM),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [143:0] mk_hdr(input logic [7:0] ver, input logic [7:0] tos,
                                            input logic [15:0] len, input logic [15:0] ident,
                                            input logic [15:0] ff, input logic [7:0] ttl,
                                            input logic [7:0] proto, input logic [31:0] src,
                                            input logic [31:0] dst);
        return {ver, tos, len, ident, ff, ttl, proto, src, dst};
    endfunction

    function automatic logic [15:0] ref_cksum(input logic [143:0] h);
        logic [31:0] s;
        s = 32'd0;
        for (int w = 0; w < 9; w++) s = s + {16'd0, h[143-16*w -: 16]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold one request until granted, then drop valid after the handshake edge.
    task automatic send(input int idx, input logic [143:0] hdr);
        int k;
        REQ_HDR[144*idx +: 144] = hdr;
        REQ_VALID[idx] = 1'b1;
        #1;
        k = 0;
        while (REQ_READY[idx] !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("send_grant", 32'(REQ_READY[idx]), 32'h1);
        tick();
        REQ_VALID[idx] = 1'b0;
    endtask

    // Hold a valid mask, check the order and spacing of the first n grants.
    task automatic run_seq(input logic [3:0] mask, input logic [11:0] seq, input int n);
        int g, last, k;
        g = 0; last = 0; k = 0;
        RSP_READY = 1'b1;
        REQ_VALID = mask;
        #1;
        while (g < n && k < 40) begin
            if (REQ_READY != '0) begin
                chk("seq_grant", 32'(REQ_READY), 32'(seq[4*g +: 4]));
                if (g > 0) chk("seq_gap", cyc - last, 3);
                last = cyc;
                g++;
            end
            if (g < n) begin
                tick();
                k++;
            end
        end
        chk("seq_count", g, n);
        tick();
        REQ_VALID = '0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 60) begin
            tick();
            k++;
        end
        chk("rsp_count", rsp_cnt, n);
    endtask

    always @(negedge CLK) begin
        logic [17:0] e;
        if (RESETN === 1'b1 && RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
            rsp_cnt++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed id=%0d cksum=%h expected no response",
                       RSP_ID, RSP_CHECKSUM);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_id", 32'(RSP_ID), 32'(e[17:16]));
                chk("rsp_cksum", 32'(RSP_CHECKSUM), 32'(e[15:0]));
            end
        end
    end

    initial begin
        logic [143:0] hb, h3, h1, h2, hw;
        logic [15:0]  e1, e2, ew;
        hb = mk_hdr(8'h45, 8'h00, 16'h0073, 16'h0000, 16'h4000, 8'h40, 8'h11,
                    32'hC0A80001, 32'hC0A800C7);
        h3 = mk_hdr(8'h45, 8'h00, 16'h0073, 16'h0000, 16'h4000, 8'h3F, 8'h11,
                    32'hC0A80001, 32'hC0A800C7);
        h1 = mk_hdr(8'h45, 8'h00, 16'h0054, 16'h1C46, 16'h4000, 8'h40, 8'h06,
                    32'h0A000001, 32'h0A000002);
        h2 = mk_hdr(8'h45, 8'h08, 16'h0200, 16'hFFFF, 16'h2000, 8'hFF, 8'h01,
                    32'hFFFFFFFF, 32'hFFFFFFFE);
        hw = mk_hdr(8'h45, 8'h10, 16'h0028, 16'hABCD, 16'h0000, 8'h80, 8'h06,
                    32'hAC100005, 32'h08080808);
        e1 = ref_cksum(h1);
        e2 = ref_cksum(h2);
        ew = ref_cksum(hw);

        RESETN    = 1'b0;
        REQ_VALID = '0;
        REQ_HDR   = '0;
        RSP_READY = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rst_rsp_id", 32'(RSP_ID), 32'h0);
        chk("rst_rsp_cksum", 32'(RSP_CHECKSUM), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_req_ready", 32'(REQ_READY), 32'h0);
        RESETN = 1'b1;
        tick();
        chk("idle_no_req_ready", 32'(REQ_READY), 32'h0);

        // Single request on requester 2, cycle-exact latency.
        RSP_READY = 1'b1;
        REQ_HDR[144*2 +: 144] = hb;
        REQ_VALID = 4'b0100;
        sb.push_back({2'd2, 16'hB861});
        #1;
        chk("t1_ready", 32'(REQ_READY), 32'h4);
        chk("t1_busy_idle", 32'(BUSY), 32'h0);
        tick();
        REQ_VALID = '0;
        chk("t1_busy_calc", 32'(BUSY), 32'h1);
        chk("t1_rsp_early", 32'(RSP_VALID), 32'h0);
        chk("t1_ready_calc", 32'(REQ_READY), 32'h0);
        tick();
        chk("t1_rsp_valid", 32'(RSP_VALID), 32'h1);
        chk("t1_rsp_id", 32'(RSP_ID), 32'h2);
        chk("t1_rsp_cksum", 32'(RSP_CHECKSUM), 32'hB861);
        tick();
        chk("t1_back_idle", 32'(BUSY), 32'h0);
        chk("t1_rsp_cleared", 32'(RSP_VALID), 32'h0);
        wait_rsp(1);

        // Grant to the last requester while the pointer sits on it wraps the pointer.
        sb.push_back({2'd3, ew});
        send(3, hw);
        wait_rsp(2);
`ifndef IPV4_CKSUM_FIXED_PRIO_EN
        chk("wrap_ptr", 32'(dut.ptr_q), 32'h0);
`endif

        // Contention between requesters 0 and 3 held valid.
        REQ_HDR[144*0 +: 144] = hb;
        REQ_HDR[144*3 +: 144] = h3;
`ifdef IPV4_CKSUM_FIXED_PRIO_EN
        sb.push_back({2'd0, 16'hB861});
        sb.push_back({2'd0, 16'hB861});
        sb.push_back({2'd0, 16'hB861});
        run_seq(4'b1001, {4'b0001, 4'b0001, 4'b0001}, 3);
`else
        sb.push_back({2'd0, 16'hB861});
        sb.push_back({2'd3, 16'hB961});
        sb.push_back({2'd0, 16'hB861});
        run_seq(4'b1001, {4'b0001, 4'b1000, 4'b0001}, 3);
`endif
        wait_rsp(5);

        // All-zero header.
        sb.push_back({2'd0, 16'hFFFF});
        send(0, '0);
        wait_rsp(6);

        // Backpressure: response held while requester 1 waits with valid high.
        RSP_READY = 1'b0;
        sb.push_back({2'd1, e1});
        sb.push_back({2'd1, e1});
        send(1, h1);
        REQ_VALID[1] = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(RSP_VALID), 32'h1);
            chk("bp_rsp_id", 32'(RSP_ID), 32'h1);
            chk("bp_rsp_cksum", 32'(RSP_CHECKSUM), 32'(e1));
            chk("bp_req_ready", 32'(REQ_READY), 32'h0);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        chk("bp_regrant", 32'(REQ_READY), 32'h2);
        tick();
        REQ_VALID = '0;
        wait_rsp(8);

        // Reset while in CALC drops the request.
        send(2, h2);
        chk("rc_in_calc", 32'(BUSY), 32'h1);
        RESETN = 1'b0;
        #1;
        chk("rc_rsp_valid", 32'(RSP_VALID), 32'h0);
        chk("rc_busy", 32'(BUSY), 32'h0);
        chk("rc_rsp_cksum", 32'(RSP_CHECKSUM), 32'h0);
`ifndef IPV4_CKSUM_FIXED_PRIO_EN
        chk("rc_ptr", 32'(dut.ptr_q), 32'h0);
`endif
        tick();
        RESETN = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("rc_no_rsp", rsp_cnt, 8);
        chk("rc_idle", 32'(BUSY), 32'h0);

        // Requesters 1 and 3 after reset: pointer restarts at 0.
        REQ_HDR[144*1 +: 144] = h1;
        REQ_HDR[144*3 +: 144] = hw;
`ifdef IPV4_CKSUM_FIXED_PRIO_EN
        sb.push_back({2'd1, e1});
        sb.push_back({2'd1, e1});
        run_seq(4'b1010, {4'b0000, 4'b0010, 4'b0010}, 2);
        wait_rsp(10);
        REQ_HDR[144*2 +: 144] = h2;
        sb.push_back({2'd1, e1});
        sb.push_back({2'd1, e1});
        sb.push_back({2'd2, e2});
        run_seq(4'b0110, {4'b0000, 4'b0010, 4'b0010}, 2);
        run_seq(4'b0100, {4'b0000, 4'b0000, 4'b0100}, 1);
        wait_rsp(13);
`else
        sb.push_back({2'd1, e1});
        sb.push_back({2'd3, ew});
        run_seq(4'b1010, {4'b0000, 4'b1000, 4'b0010}, 2);
        wait_rsp(10);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
